// File: rtl/rf_pkg.sv
// Shared constants and buffer-state encoding for the register-file writeback controller.
package rf_pkg;

    localparam int NUM_REGS = 32;
    localparam int AW       = 5;
    localparam int DW       = 32;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry writeback holding buffer with a valid/ready input side.
// The entry can be granted and refilled at the same edge, so a steady stream sustains one write per cycle.
module wb_skid_buf
    import rf_pkg::*;
#(
    parameter int AW = rf_pkg::AW,
    parameter int DW = rf_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          grant,
    output logic          full,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data
);

    buf_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          accept;

    assign full     = (state_q == BUF_FULL);
    assign in_ready = (state_q == BUF_EMPTY) | grant;
    assign accept   = in_valid & in_ready;
    assign out_addr = addr_q;
    assign out_data = data_q;

    // Next entry state: a refill takes precedence over the drain caused by a grant.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (accept) begin
            state_d = BUF_FULL;
            addr_d  = in_addr;
            data_d  = in_data;
        end else if (grant) begin
            state_d = BUF_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // Entry registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BUF_EMPTY;
            addr_q  <= {AW{1'b0}};
            data_q  <= {DW{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Shares the register-file write port between ALU (port 0) and LSU (port 1) writebacks and tracks busy destinations.
// Optional macro WB_ROUND_ROBIN_EN: round-robin on contention; otherwise port 1 has fixed priority.
module rf_writeback_ctrl
    import rf_pkg::*;
#(
    parameter int NUM_REGS = rf_pkg::NUM_REGS,
    parameter int AW       = rf_pkg::AW,
    parameter int DW       = rf_pkg::DW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb0_valid,
    output logic                wb0_ready,
    input  logic [AW-1:0]       wb0_addr,
    input  logic [DW-1:0]       wb0_data,
    input  logic                wb1_valid,
    output logic                wb1_ready,
    input  logic [AW-1:0]       wb1_addr,
    input  logic [DW-1:0]       wb1_data,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    input  logic [AW-1:0]       rs1_addr,
    input  logic [AW-1:0]       rs2_addr,
    output logic                hazard,
    output logic [AW-1:0]       R3_addr,
    output logic [DW-1:0]       R3_data,
    output logic                R3_wr_en,
    output logic [NUM_REGS-1:0] busy_debug
);

    logic                full0, full1;
    logic                grant0, grant1, grant_any;
    logic [AW-1:0]       buf0_addr, buf1_addr, gnt_addr;
    logic [DW-1:0]       buf0_data, buf1_data, gnt_data;
    logic [AW-1:0]       r3_addr_q, r3_addr_d;
    logic [DW-1:0]       r3_data_q, r3_data_d;
    logic                r3_wr_en_q, r3_wr_en_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
`ifdef WB_ROUND_ROBIN_EN
    logic                rr_q, rr_d;
`endif

    wb_skid_buf #(.AW(AW), .DW(DW)) u_buf0 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (wb0_valid),
        .in_ready (wb0_ready),
        .in_addr  (wb0_addr),
        .in_data  (wb0_data),
        .grant    (grant0),
        .full     (full0),
        .out_addr (buf0_addr),
        .out_data (buf0_data)
    );

    wb_skid_buf #(.AW(AW), .DW(DW)) u_buf1 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (wb1_valid),
        .in_ready (wb1_ready),
        .in_addr  (wb1_addr),
        .in_data  (wb1_data),
        .grant    (grant1),
        .full     (full1),
        .out_addr (buf1_addr),
        .out_data (buf1_data)
    );

    // Grant selection: at most one full buffer per cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef WB_ROUND_ROBIN_EN
        rr_d   = rr_q;
        if (full0 & full1) begin
            grant0 = ~rr_q;
            grant1 = rr_q;
            rr_d   = ~rr_q;
        end else begin
            grant0 = full0;
            grant1 = full1;
            rr_d   = rr_q;
        end
`else
        grant1 = full1;
        grant0 = full0 & ~full1;
`endif
        grant_any = grant0 | grant1;
        if (grant1) begin
            gnt_addr = buf1_addr;
            gnt_data = buf1_data;
        end else begin
            gnt_addr = buf0_addr;
            gnt_data = buf0_data;
        end
    end

    // Write-port and scoreboard update; a same-cycle reservation beats the clear.
    always_comb begin
        r3_addr_d  = r3_addr_q;
        r3_data_d  = r3_data_q;
        r3_wr_en_d = 1'b0;
        busy_d     = busy_q;
        if (grant_any) begin
            r3_addr_d  = gnt_addr;
            r3_data_d  = gnt_data;
            r3_wr_en_d = (gnt_addr != {AW{1'b0}});
            if (gnt_addr != {AW{1'b0}}) begin
                busy_d[gnt_addr] = 1'b0;
            end else begin
                busy_d = busy_d;
            end
        end else begin
            r3_wr_en_d = 1'b0;
        end
        if (issue_valid && (issue_rd != {AW{1'b0}})) begin
            busy_d[issue_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r3_addr_q  <= {AW{1'b0}};
            r3_data_q  <= {DW{1'b0}};
            r3_wr_en_q <= 1'b0;
            busy_q     <= {NUM_REGS{1'b0}};
        end else begin
            r3_addr_q  <= r3_addr_d;
            r3_data_q  <= r3_data_d;
            r3_wr_en_q <= r3_wr_en_d;
            busy_q     <= busy_d;
        end
    end

`ifdef WB_ROUND_ROBIN_EN
    // Round-robin pointer: 0 favours port 0 on the next contested cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign hazard = ((rs1_addr != {AW{1'b0}}) & busy_q[rs1_addr]) |
                    ((rs2_addr != {AW{1'b0}}) & busy_q[rs2_addr]);

    assign R3_addr    = r3_addr_q;
    assign R3_data    = r3_data_q;
    assign R3_wr_en   = r3_wr_en_q;
    assign busy_debug = busy_q;

endmodule
